dmem_access_sequencer: RTL and testbench
========================================

Name: dmem_access_sequencer

Overview:
- Sequences every access to the single-port, synchronous-read data memory in the MEMORY stage.
- Shares that port between the pipeline load/store path (priority) and the debug unit's word-read path.
- Aligns sub-word load data to bit 0 for the downstream sign/zero-extension logic.
- Runs sub-word stores as read-modify-write and stalls the pipeline while a multi-cycle access is in flight.

Parameters:
NB_DATA, 32, data width (fixed 4 byte lanes)
NB_ADDR, 10, memory word-address width
NB_TYPE, 3, word-size code width (`BYTE_WORD`, `HALF_WORD`, `COMPLETE_WORD` from shared parameters header)

Ports:
i_clock  in  1  clock, rising edge
i_reset  in  1  asynchronous, active-low reset
i_pipe_read  in  1  pipeline load request (level, held while stalled)
i_pipe_write  in  1  pipeline store request (level, held while stalled)
i_pipe_word_size  in  NB_TYPE  access size code
i_pipe_addr  in  NB_ADDR+2  byte address; [NB_ADDR+1:2] word index, [1:0] lane
i_pipe_wdata  in  NB_DATA  store data, sub-word in low bits
o_pipe_rdata  out  NB_DATA  load data, lane shifted to bit 0, upper bits unmodified memory content
o_pipe_stall  out  1  hold PC/IF/ID/EX/MEM registers (combinational)
o_addr_error  out  1  one-cycle pulse: misaligned or unknown-size request dropped
i_dbg_req  in  1  debug word-read request (level, held until o_dbg_valid)
i_dbg_addr  in  NB_ADDR  debug word address
o_dbg_rdata  out  NB_DATA  registered debug read data
o_dbg_valid  out  1  one-cycle pulse, o_dbg_rdata valid
o_mem_en  out  1  memory enable
o_mem_we  out  1  memory write enable
o_mem_addr  out  NB_ADDR  memory word address
o_mem_wdata  out  NB_DATA  memory write data
i_mem_rdata  in  NB_DATA  memory read data, valid one cycle after o_mem_en with o_mem_we=0

Behaviour:
- States: IDLE, P_LOAD, RMW_RD, RMW_WR, DBG_RD. Reset (async, i_reset=0): state=IDLE; o_dbg_rdata=0; o_dbg_valid=0; o_addr_error=0; all combinational outputs 0; no write in flight.
- Alignment check in IDLE: HALF requires lane[0]=0; COMPLETE requires lane=0; unknown size code is an error.
  - Failing request: o_addr_error=1 for one cycle, no memory access, no stall, o_pipe_rdata=0; request is consumed.
- Read and write both asserted: treated as a read; write ignored.
- IDLE + pipe read: o_mem_en=1, we=0, addr=word index, o_pipe_stall=1, next P_LOAD.
- P_LOAD: o_pipe_rdata = i_mem_rdata >> (8*lane); stall=0; next IDLE. Load latency: 2 cycles, 1 stall cycle.
- IDLE + pipe write, COMPLETE: en=1, we=1, wdata=i_pipe_wdata, no stall, stay IDLE (0 stall cycles).
- IDLE + pipe write, BYTE/HALF: issue read, stall=1, latch lane/size/wdata, next RMW_RD.
- RMW_RD: merge the latched sub-word into i_mem_rdata at lane (byte: 8 bits at 8*lane; half: 16 bits at 8*lane). Write the merge (en=1, we=1), stall=0, next IDLE.
  - RMW_WR is the registered variant: it is entered only when the merge is registered. Implementation selects one variant; the stall count is fixed at 1 cycle either way.
- Pipe request in a non-IDLE state is not re-issued. The pipeline holds inputs during stall, and the releasing cycle retires them.
- Debug: serviced only in IDLE with no pipe request (strict pipeline priority; starvation accepted, since debug runs with the pipeline halted).
  - IDLE + i_dbg_req: en=1, we=0, addr=i_dbg_addr, next DBG_RD.
  - DBG_RD: o_dbg_rdata<=i_mem_rdata, o_dbg_valid=1 next cycle, next IDLE. A request held after valid starts a new read.
- o_pipe_rdata=0 outside P_LOAD. o_mem_* = 0 when en=0.
- Reset mid-RMW: the pending write is abandoned; memory keeps its old word.

Test Plan:
- Word store addr 0x010, data 0xDEADBEEF, then word load 0x010 -> no stall on store; load stalls 1 cycle; o_pipe_rdata=0xDEADBEEF.
- Byte store 0xA5 to addr 0x012 over word 0x11223344 -> 1 stall, memory word 0x11A53344. Byte load 0x012 -> o_pipe_rdata low byte 0xA5.
- Half store 0xBEEF to addr 0x006 over 0x00000000 -> word 0xBEEF0000. Half load at 0x005 -> o_addr_error pulse, no o_mem_en, no stall.
- i_dbg_req addr 4 in the same cycle as a pipe load -> pipe load served first. Debug read issues the next IDLE cycle; o_dbg_valid pulses with the word at index 4.
- Assert i_reset low during RMW_RD of a byte store -> outputs 0 immediately, state IDLE, target word unchanged.
- Unknown size code 3'b111 with read -> o_addr_error=1, o_pipe_rdata=0, no stall.

Source files
------------

// File: rtl/dmem_access_sequencer_if.sv
// Bus bundle between the MEMORY-stage pipeline, the debug unit, the data
// memory and the access sequencer. The sequencer uses the slave view.
interface dmem_access_sequencer_if #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 10,
  parameter int NB_TYPE = 3
);
  logic                 i_pipe_read;
  logic                 i_pipe_write;
  logic [NB_TYPE-1:0]   i_pipe_word_size;
  logic [NB_ADDR+1:0]   i_pipe_addr;
  logic [NB_DATA-1:0]   i_pipe_wdata;
  logic [NB_DATA-1:0]   o_pipe_rdata;
  logic                 o_pipe_stall;
  logic                 o_addr_error;
  logic                 i_dbg_req;
  logic [NB_ADDR-1:0]   i_dbg_addr;
  logic [NB_DATA-1:0]   o_dbg_rdata;
  logic                 o_dbg_valid;
  logic                 o_mem_en;
  logic                 o_mem_we;
  logic [NB_ADDR-1:0]   o_mem_addr;
  logic [NB_DATA-1:0]   o_mem_wdata;
  logic [NB_DATA-1:0]   i_mem_rdata;

  modport slave (
    input  i_pipe_read, i_pipe_write, i_pipe_word_size, i_pipe_addr, i_pipe_wdata,
    output o_pipe_rdata, o_pipe_stall, o_addr_error,
    input  i_dbg_req, i_dbg_addr,
    output o_dbg_rdata, o_dbg_valid,
    output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
    input  i_mem_rdata
  );

  modport master (
    output i_pipe_read, i_pipe_write, i_pipe_word_size, i_pipe_addr, i_pipe_wdata,
    input  o_pipe_rdata, o_pipe_stall, o_addr_error,
    output i_dbg_req, i_dbg_addr,
    input  o_dbg_rdata, o_dbg_valid,
    input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
    output i_mem_rdata
  );
endinterface

// File: rtl/dmem_access_sequencer.sv
// Arbitrates the single-port data memory between pipeline loads/stores and
// debug word reads; sub-word stores are done as read-modify-write.
module dmem_access_sequencer #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 10,
  parameter int NB_TYPE = 3,
  parameter logic [NB_TYPE-1:0] BYTE_WORD     = 3'b001,
  parameter logic [NB_TYPE-1:0] HALF_WORD     = 3'b010,
  parameter logic [NB_TYPE-1:0] COMPLETE_WORD = 3'b100
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  dmem_access_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    P_LOAD = 3'd1,
    RMW_RD = 3'd2,
    RMW_WR = 3'd3,
    DBG_RD = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           lane_q, lane_d;
  logic [NB_TYPE-1:0]   size_q, size_d;
  logic [NB_DATA-1:0]   wdata_q, wdata_d;
  logic [NB_ADDR-1:0]   addr_q, addr_d;
  logic [NB_DATA-1:0]   dbg_rdata_q, dbg_rdata_d;
  logic                 dbg_valid_q, dbg_valid_d;
  logic                 addr_error_q, addr_error_d;

  logic                 mem_en_s, mem_we_s, pipe_stall_s;
  logic [NB_ADDR-1:0]   mem_addr_s;
  logic [NB_DATA-1:0]   mem_wdata_s, pipe_rdata_s;
  logic [NB_ADDR-1:0]   pipe_word_s;
  logic [1:0]           pipe_lane_s;
  logic                 pipe_req_s;

  assign pipe_word_s = bus.i_pipe_addr[NB_ADDR+1:2];
  assign pipe_lane_s = bus.i_pipe_addr[1:0];
  assign pipe_req_s  = bus.i_pipe_read | bus.i_pipe_write;

  function automatic logic access_ok(input logic [NB_TYPE-1:0] size, input logic [1:0] lane);
    logic ok;
    case (size)
      BYTE_WORD:     ok = 1'b1;
      HALF_WORD:     ok = ~lane[0];
      COMPLETE_WORD: ok = (lane == 2'b00);
      default:       ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Only the addressed lanes of the old word are replaced by the store data.
  function automatic logic [NB_DATA-1:0] merge_lane(input logic [NB_DATA-1:0] old_word,
                                                    input logic [NB_DATA-1:0] sub,
                                                    input logic [NB_TYPE-1:0] size,
                                                    input logic [1:0]         lane);
    logic [NB_DATA-1:0] mask;
    logic [4:0]         sh;
    sh = {lane, 3'b000};
    if (size == HALF_WORD) begin
      mask = {{(NB_DATA-16){1'b0}}, 16'hFFFF};
    end else begin
      mask = {{(NB_DATA-8){1'b0}}, 8'hFF};
    end
    return (old_word & ~(mask << sh)) | ((sub & mask) << sh);
  endfunction

  // Next-state, memory port and pipeline response decode.
  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    size_d       = size_q;
    wdata_d      = wdata_q;
    addr_d       = addr_q;
    dbg_rdata_d  = dbg_rdata_q;
    dbg_valid_d  = 1'b0;
    addr_error_d = 1'b0;
    mem_en_s     = 1'b0;
    mem_we_s     = 1'b0;
    mem_addr_s   = '0;
    mem_wdata_s  = '0;
    pipe_stall_s = 1'b0;
    pipe_rdata_s = '0;
    // Holding reset silences the memory port even while the pipeline keeps its request up.
    if (!i_reset) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (pipe_req_s) begin
            if (!access_ok(bus.i_pipe_word_size, pipe_lane_s)) begin
              addr_error_d = 1'b1;
            end else if (bus.i_pipe_read) begin
              mem_en_s     = 1'b1;
              mem_addr_s   = pipe_word_s;
              pipe_stall_s = 1'b1;
              lane_d       = pipe_lane_s;
              state_d      = P_LOAD;
            end else if (bus.i_pipe_word_size == COMPLETE_WORD) begin
              mem_en_s    = 1'b1;
              mem_we_s    = 1'b1;
              mem_addr_s  = pipe_word_s;
              mem_wdata_s = bus.i_pipe_wdata;
            end else begin
              mem_en_s     = 1'b1;
              mem_addr_s   = pipe_word_s;
              pipe_stall_s = 1'b1;
              lane_d       = pipe_lane_s;
              size_d       = bus.i_pipe_word_size;
              wdata_d      = bus.i_pipe_wdata;
              addr_d       = pipe_word_s;
              state_d      = RMW_RD;
            end
          end else if (bus.i_dbg_req) begin
            mem_en_s   = 1'b1;
            mem_addr_s = bus.i_dbg_addr;
            state_d    = DBG_RD;
          end else begin
            state_d = IDLE;
          end
        end
        P_LOAD: begin
          pipe_rdata_s = bus.i_mem_rdata >> {lane_q, 3'b000};
          state_d      = IDLE;
        end
        RMW_RD: begin
          mem_en_s    = 1'b1;
          mem_we_s    = 1'b1;
          mem_addr_s  = addr_q;
          mem_wdata_s = merge_lane(bus.i_mem_rdata, wdata_q, size_q, lane_q);
          state_d     = IDLE;
        end
        DBG_RD: begin
          dbg_rdata_d = bus.i_mem_rdata;
          dbg_valid_d = 1'b1;
          state_d     = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and registered-output flops.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= IDLE;
      lane_q       <= 2'b00;
      size_q       <= '0;
      wdata_q      <= '0;
      addr_q       <= '0;
      dbg_rdata_q  <= '0;
      dbg_valid_q  <= 1'b0;
      addr_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      size_q       <= size_d;
      wdata_q      <= wdata_d;
      addr_q       <= addr_d;
      dbg_rdata_q  <= dbg_rdata_d;
      dbg_valid_q  <= dbg_valid_d;
      addr_error_q <= addr_error_d;
    end
  end

  assign bus.o_mem_en     = mem_en_s;
  assign bus.o_mem_we     = mem_we_s;
  assign bus.o_mem_addr   = mem_addr_s;
  assign bus.o_mem_wdata  = mem_wdata_s;
  assign bus.o_pipe_stall = pipe_stall_s;
  assign bus.o_pipe_rdata = pipe_rdata_s;
  assign bus.o_addr_error = addr_error_q;
  assign bus.o_dbg_rdata  = dbg_rdata_q;
  assign bus.o_dbg_valid  = dbg_valid_q;

endmodule

// File: tb/tb_dmem_access_sequencer.sv
// Bench for dmem_access_sequencer: directed scenarios plus a randomized run
// checked against a byte-addressed memory model.
module tb_dmem_access_sequencer;
  localparam logic [2:0] SZ_B = 3'b001;
  localparam logic [2:0] SZ_H = 3'b010;
  localparam logic [2:0] SZ_W = 3'b100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_access_sequencer_if #(.NB_DATA(32), .NB_ADDR(10), .NB_TYPE(3)) bus();

  dmem_access_sequencer #(.NB_DATA(32), .NB_ADDR(10), .NB_TYPE(3)) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  // Synchronous-read memory behind the sequencer, plus a bench preload path.
  logic [31:0] mem [0:1023];
  logic [31:0] mem_rdata = 32'h0;
  logic        pl_en = 1'b0;
  logic [9:0]  pl_addr = 10'h0;
  logic [31:0] pl_data = 32'h0;
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bus.o_mem_en) begin
      if (bus.o_mem_we) mem[bus.o_mem_addr] <= bus.o_mem_wdata;
      else mem_rdata <= mem[bus.o_mem_addr];
    end
  end
  assign bus.i_mem_rdata = mem_rdata;

  // Reference model: memory as individual bytes, little-endian lanes.
  logic [7:0] ref_b [0:4095];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [31:0] ref_word(input int w);
    return {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [11:0] a);
    return ref_word(int'(a[11:2])) >> (8 * int'(a[1:0]));
  endfunction

  function automatic int size_bytes(input logic [2:0] sz);
    if (sz == SZ_B) return 1;
    if (sz == SZ_H) return 2;
    if (sz == SZ_W) return 4;
    return 0;
  endfunction

  function automatic bit legal(input logic [2:0] sz, input logic [11:0] a);
    int nb;
    nb = size_bytes(sz);
    return (nb != 0) && ((int'(a[1:0]) % nb) == 0);
  endfunction

  task automatic ref_store(input logic [2:0] sz, input logic [11:0] a, input logic [31:0] wd);
    for (int i = 0; i < size_bytes(sz); i++) ref_b[int'(a) + i] = wd[8*i +: 8];
  endtask

  task automatic preload(input int w, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = w[9:0]; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
    for (int i = 0; i < 4; i++) ref_b[4*w+i] = d[8*i +: 8];
  endtask

  task automatic clear_inputs();
    bus.i_pipe_read = 1'b0; bus.i_pipe_write = 1'b0; bus.i_pipe_word_size = 3'b000;
    bus.i_pipe_addr = 12'h000; bus.i_pipe_wdata = 32'h0;
  endtask

  // Drives one pipeline request, holding it while stalled; reports what was seen.
  task automatic pipe_op(input bit rd, input bit wr, input logic [2:0] sz, input logic [11:0] a,
                         input logic [31:0] wd, output int stalls, output logic [31:0] rdata,
                         output bit err, output bit en_seen);
    bit done;
    @(negedge clk);
    bus.i_pipe_read = rd; bus.i_pipe_write = wr; bus.i_pipe_word_size = sz;
    bus.i_pipe_addr = a; bus.i_pipe_wdata = wd;
    stalls = 0; rdata = 32'h0; en_seen = 1'b0; done = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (bus.o_mem_en) en_seen = 1'b1;
      if (bus.o_pipe_stall) stalls++;
      else begin
        rdata = bus.o_pipe_rdata;
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL pipe_timeout: stall still high after 6 cycles, required release");
    end
    @(negedge clk);
    clear_inputs();
    #1 err = bus.o_addr_error;
  endtask

  task automatic do_dbg(input logic [9:0] w, output logic [31:0] data, output int waits);
    bit ok;
    @(negedge clk);
    bus.i_dbg_req = 1'b1; bus.i_dbg_addr = w;
    ok = 1'b0; data = 32'h0; waits = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk); #1;
      if (bus.o_dbg_valid) begin
        data = bus.o_dbg_rdata; waits = c; ok = 1'b1;
        break;
      end
    end
    bus.i_dbg_req = 1'b0;
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL dbg_timeout: no o_dbg_valid within 8 cycles");
    end
  endtask

  int st; logic [31:0] rd_v; bit er; bit en;

  task automatic test_reset();
    clear_inputs();
    bus.i_dbg_req = 1'b0; bus.i_dbg_addr = 10'h0;
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if ({bus.o_mem_en, bus.o_mem_we, bus.o_pipe_stall, bus.o_addr_error, bus.o_dbg_valid} !== 5'b00000) begin
      n_bad++; $display("FAIL reset_ctrl: got %b required 00000",
        {bus.o_mem_en, bus.o_mem_we, bus.o_pipe_stall, bus.o_addr_error, bus.o_dbg_valid});
    end
    n_cmp++;
    if ({bus.o_mem_addr, bus.o_mem_wdata, bus.o_pipe_rdata, bus.o_dbg_rdata} !== 106'h0) begin
      n_bad++; $display("FAIL reset_data: addr %h wdata %h prd %h drd %h required all 0",
        bus.o_mem_addr, bus.o_mem_wdata, bus.o_pipe_rdata, bus.o_dbg_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_word_store_load();
    preload(4, 32'h0);
    pipe_op(1'b0, 1'b1, SZ_W, 12'h010, 32'hDEADBEEF, st, rd_v, er, en);
    ref_store(SZ_W, 12'h010, 32'hDEADBEEF);
    n_cmp++;
    if (st !== 0 || en !== 1'b1) begin
      n_bad++; $display("FAIL word_store_timing: stalls %0d en %b required 0 1", st, en);
    end
    n_cmp++;
    if (mem[4] !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL word_store_mem: got %h required DEADBEEF", mem[4]);
    end
    pipe_op(1'b1, 1'b0, SZ_W, 12'h010, 32'h0, st, rd_v, er, en);
    n_cmp++;
    if (st !== 1 || rd_v !== ref_load(12'h010) || er !== 1'b0) begin
      n_bad++; $display("FAIL word_load: stalls %0d data %h err %b required 1 %h 0", st, rd_v, er, ref_load(12'h010));
    end
  endtask

  task automatic test_byte_store();
    preload(4, 32'h11223344);
    pipe_op(1'b0, 1'b1, SZ_B, 12'h012, 32'hFFFFFFA5, st, rd_v, er, en);
    ref_store(SZ_B, 12'h012, 32'hFFFFFFA5);
    n_cmp++;
    if (st !== 1 || mem[4] !== 32'h11A53344) begin
      n_bad++; $display("FAIL byte_store: stalls %0d word %h required 1 11A53344", st, mem[4]);
    end
    pipe_op(1'b1, 1'b0, SZ_B, 12'h012, 32'h0, st, rd_v, er, en);
    n_cmp++;
    if (st !== 1 || rd_v[7:0] !== 8'hA5 || rd_v !== ref_load(12'h012)) begin
      n_bad++; $display("FAIL byte_load: stalls %0d data %h required 1 %h", st, rd_v, ref_load(12'h012));
    end
  endtask

  task automatic test_half_store_misaligned();
    preload(1, 32'h0);
    pipe_op(1'b0, 1'b1, SZ_H, 12'h006, 32'h1234BEEF, st, rd_v, er, en);
    ref_store(SZ_H, 12'h006, 32'h1234BEEF);
    n_cmp++;
    if (st !== 1 || mem[1] !== 32'hBEEF0000) begin
      n_bad++; $display("FAIL half_store: stalls %0d word %h required 1 BEEF0000", st, mem[1]);
    end
    pipe_op(1'b1, 1'b0, SZ_H, 12'h005, 32'h0, st, rd_v, er, en);
    n_cmp++;
    if (er !== 1'b1 || en !== 1'b0 || st !== 0 || rd_v !== 32'h0) begin
      n_bad++; $display("FAIL half_misaligned: err %b en %b stalls %0d data %h required 1 0 0 0", er, en, st, rd_v);
    end
    n_cmp++;
    #10;
    if (bus.o_addr_error !== 1'b0) begin
      n_bad++; $display("FAIL err_pulse_width: err %b one cycle later, required 0", bus.o_addr_error);
    end
  endtask

  task automatic test_unknown_size();
    pipe_op(1'b1, 1'b0, 3'b111, 12'h010, 32'h0, st, rd_v, er, en);
    n_cmp++;
    if (er !== 1'b1 || en !== 1'b0 || st !== 0 || rd_v !== 32'h0) begin
      n_bad++; $display("FAIL unknown_size_rd: err %b en %b stalls %0d data %h required 1 0 0 0", er, en, st, rd_v);
    end
    pipe_op(1'b0, 1'b1, 3'b111, 12'h010, 32'h55555555, st, rd_v, er, en);
    n_cmp++;
    if (er !== 1'b1 || mem[4] !== ref_word(4)) begin
      n_bad++; $display("FAIL unknown_size_wr: err %b word %h required 1 %h", er, mem[4], ref_word(4));
    end
  endtask

  task automatic test_read_and_write();
    preload(3, 32'h0BADF00D);
    pipe_op(1'b1, 1'b1, SZ_W, 12'h00C, 32'h99999999, st, rd_v, er, en);
    n_cmp++;
    if (st !== 1 || rd_v !== 32'h0BADF00D || mem[3] !== 32'h0BADF00D) begin
      n_bad++; $display("FAIL rd_wr_both: stalls %0d data %h word %h required 1 0BADF00D 0BADF00D", st, rd_v, mem[3]);
    end
  endtask

  task automatic test_dbg_priority();
    preload(2, 32'h22222222);
    preload(4, 32'h44444444);
    @(negedge clk);
    bus.i_pipe_read = 1'b1; bus.i_pipe_word_size = SZ_W; bus.i_pipe_addr = 12'h008;
    bus.i_dbg_req = 1'b1; bus.i_dbg_addr = 10'd4;
    #1;
    n_cmp++;
    if (bus.o_mem_en !== 1'b1 || bus.o_mem_addr !== 10'd2 || bus.o_pipe_stall !== 1'b1) begin
      n_bad++; $display("FAIL dbg_prio_issue: en %b addr %0d stall %b required 1 2 1", bus.o_mem_en, bus.o_mem_addr, bus.o_pipe_stall);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (bus.o_pipe_rdata !== ref_word(2) || bus.o_pipe_stall !== 1'b0 || bus.o_mem_en !== 1'b0) begin
      n_bad++; $display("FAIL dbg_prio_load: data %h stall %b en %b required %h 0 0", bus.o_pipe_rdata, bus.o_pipe_stall, bus.o_mem_en, ref_word(2));
    end
    clear_inputs();
    @(negedge clk); #1;
    n_cmp++;
    if (bus.o_mem_en !== 1'b1 || bus.o_mem_we !== 1'b0 || bus.o_mem_addr !== 10'd4) begin
      n_bad++; $display("FAIL dbg_issue: en %b we %b addr %0d required 1 0 4", bus.o_mem_en, bus.o_mem_we, bus.o_mem_addr);
    end
    @(negedge clk);
    @(negedge clk); #1;
    n_cmp++;
    if (bus.o_dbg_valid !== 1'b1 || bus.o_dbg_rdata !== ref_word(4)) begin
      n_bad++; $display("FAIL dbg_data: valid %b data %h required 1 %h", bus.o_dbg_valid, bus.o_dbg_rdata, ref_word(4));
    end
    bus.i_dbg_req = 1'b0;
    @(negedge clk); #1;
    n_cmp++;
    if (bus.o_dbg_valid !== 1'b0 || bus.o_mem_en !== 1'b0) begin
      n_bad++; $display("FAIL dbg_pulse: valid %b en %b required 0 0", bus.o_dbg_valid, bus.o_mem_en);
    end
  endtask

  task automatic test_reset_mid_rmw();
    preload(8, 32'hCAFEF00D);
    @(negedge clk);
    bus.i_pipe_write = 1'b1; bus.i_pipe_word_size = SZ_B; bus.i_pipe_addr = 12'h021; bus.i_pipe_wdata = 32'h00000077;
    @(negedge clk); #1;
    n_cmp++;
    if (bus.o_mem_en !== 1'b1 || bus.o_mem_we !== 1'b1) begin
      n_bad++; $display("FAIL rmw_write_phase: en %b we %b required 1 1", bus.o_mem_en, bus.o_mem_we);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.o_mem_en, bus.o_mem_we, bus.o_pipe_stall, bus.o_addr_error, bus.o_dbg_valid} !== 5'b00000
        || bus.o_pipe_rdata !== 32'h0 || bus.o_mem_wdata !== 32'h0) begin
      n_bad++; $display("FAIL rmw_reset_outputs: ctrl %b wdata %h required 00000 0",
        {bus.o_mem_en, bus.o_mem_we, bus.o_pipe_stall, bus.o_addr_error, bus.o_dbg_valid}, bus.o_mem_wdata);
    end
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (mem[8] !== ref_word(8)) begin
      n_bad++; $display("FAIL rmw_reset_mem: word %h required %h", mem[8], ref_word(8));
    end
  endtask

  task automatic test_random();
    logic [2:0]  sizes [3] = '{SZ_B, SZ_H, SZ_W};
    logic [2:0]  sz;
    logic [11:0] a;
    logic [31:0] wd, dd, exp_rd;
    int kind, w, waits, exp_st;
    bit rd, wr;
    for (int i = 0; i < 16; i++) preload(i, $urandom);
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 5);
      w = $urandom_range(0, 15);
      wd = $urandom;
      if (kind == 4) begin
        do_dbg(w[9:0], dd, waits);
        n_cmp++;
        if (dd !== ref_word(w) || waits !== 2) begin
          n_bad++; $display("FAIL rnd_dbg[%0d]: data %h wait %0d required %h 2", n, dd, waits, ref_word(w));
        end
      end else begin
        rd = (kind == 0) || (kind == 2) || (kind == 3 && $urandom_range(0, 1) == 1);
        wr = (kind != 0) && !(kind == 3 && rd);
        if (kind == 3) begin
          do begin
            sz = 3'($urandom_range(0, 7));
            a = {w[9:0], 2'($urandom_range(0, 3))};
          end while (legal(sz, a));
        end else begin
          sz = (kind == 5) ? SZ_W : sizes[$urandom_range(0, 2)];
          a = {w[9:0], 2'($urandom_range(0, 3))};
          a[1:0] = (size_bytes(sz) == 4) ? 2'b00 : (size_bytes(sz) == 2) ? (a[1:0] & 2'b10) : a[1:0];
        end
        pipe_op(rd, wr, sz, a, wd, st, rd_v, er, en);
        if (!legal(sz, a)) begin
          n_cmp++;
          if (er !== 1'b1 || st !== 0 || en !== 1'b0 || rd_v !== 32'h0) begin
            n_bad++; $display("FAIL rnd_err[%0d]: err %b stalls %0d en %b data %h required 1 0 0 0", n, er, st, en, rd_v);
          end
        end else begin
          exp_st = (rd || sz != SZ_W) ? 1 : 0;
          exp_rd = rd ? ref_load(a) : 32'h0;
          if (wr && !rd) ref_store(sz, a, wd);
          n_cmp++;
          if (er !== 1'b0 || st !== exp_st || rd_v !== exp_rd) begin
            n_bad++; $display("FAIL rnd_op[%0d]: rd %b wr %b sz %b a %h: err %b stalls %0d data %h required 0 %0d %h",
              n, rd, wr, sz, a, er, st, rd_v, exp_st, exp_rd);
          end
        end
        n_cmp++;
        if (mem[w] !== ref_word(w)) begin
          n_bad++; $display("FAIL rnd_mem[%0d]: word %0d got %h required %h", n, w, mem[w], ref_word(w));
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_word_store_load();
    test_byte_store();
    test_half_store_misaligned();
    test_unknown_size();
    test_read_and_write();
    test_dbg_priority();
    test_reset_mid_rmw();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
